// File: rtl/trapezoid_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// trapezoid_step_sequencer_if
// Bundles the command handshake, the PWM-channel drive/feedback and the
// status outputs of one trapezoid step sequencer.
//   slave  : sequencer side (accepts commands, drives the PWM channel)
//   master : step-command source / channel model side
// Signals:
//   CMD_VALID, CMD_READY, CMD_LEVEL[7:0], CMD_DIV[7:0], ABORT  command path
//   PWMBP, D[7:0], L, CE, ZERO                                 PWM channel
//   BUSY, DONE, ABORTED                                        status
// -----------------------------------------------------------------------------
interface trapezoid_step_sequencer_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] CMD_LEVEL;
  logic [7:0] CMD_DIV;
  logic       ABORT;
  logic       PWMBP;
  logic [7:0] D;
  logic       L;
  logic       CE;
  logic       ZERO;
  logic       BUSY;
  logic       DONE;
  logic       ABORTED;

  modport slave (
    input  CMD_VALID, CMD_LEVEL, CMD_DIV, ABORT, ZERO,
    output CMD_READY, PWMBP, D, L, CE, BUSY, DONE, ABORTED
  );

  modport master (
    output CMD_VALID, CMD_LEVEL, CMD_DIV, ABORT, ZERO,
    input  CMD_READY, PWMBP, D, L, CE, BUSY, DONE, ABORTED
  );
endinterface

// File: rtl/trapezoid_step_sequencer.sv
// -----------------------------------------------------------------------------
// trapezoid_step_sequencer
// Sequences one trapezoid PWM current channel: free-running PWM base-period
// strobe, start-level load, ramp count-enables every CMD_DIV base periods,
// and ramp completion via the channel's ZERO flag (qualified by a CE having
// been issued), with abort support.
// Ports:
//   CLK   system clock, rising edge
//   RSTN  asynchronous active-low reset
//   bus   trapezoid_step_sequencer_if.slave (command, channel, status)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | ready for a command, CMD_READY=1
// LOAD   | one cycle, L=1 with D=latched start level
// RAMP   | CE every div base periods, wait for qualified ZERO or ABORT
// FIN    | one cycle, DONE=1
// KILL   | one cycle, L=1 with D=0, ABORTED=1
// -----------------------------------------------------------------------------
module trapezoid_step_sequencer #(
  parameter int PWM_PERIOD = 2048
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  trapezoid_step_sequencer_if.slave     bus
);

  localparam int PW = $clog2(PWM_PERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(PWM_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RAMP,
    S_FIN,
    S_KILL
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          pwmbp_q, pwmbp_d;
  logic [7:0]    level_q, level_d;
  logic [7:0]    div_q, div_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic          ce_seen_q, ce_seen_d;

  logic          cmd_ready;
  logic          busy;
  logic          l_out;
  logic [7:0]    d_out;
  logic          ce_out;
  logic          done_out;
  logic          aborted_out;

  // Period counter runs regardless of FSM state; the strobe is registered so
  // it appears in the cycle after the wrap edge.
  always_comb begin
    if (per_cnt_q == PER_LAST) begin
      per_cnt_d = '0;
      pwmbp_d   = 1'b1;
    end else begin
      per_cnt_d = per_cnt_q + 1'b1;
      pwmbp_d   = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    div_d       = div_q;
    div_cnt_d   = div_cnt_q;
    ce_seen_d   = ce_seen_q;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    l_out       = 1'b0;
    d_out       = 8'd0;
    ce_out      = 1'b0;
    done_out    = 1'b0;
    aborted_out = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.CMD_VALID) begin
          level_d = bus.CMD_LEVEL;
          div_d   = (bus.CMD_DIV == 8'd0) ? 8'd1 : bus.CMD_DIV;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        l_out     = 1'b1;
        d_out     = level_q;
        div_cnt_d = 8'd0;
        ce_seen_d = 1'b0;
        // The load strobe is already out this cycle; an abort here only
        // redirects to KILL so the channel is zeroed next.
        state_d   = bus.ABORT ? S_KILL : S_RAMP;
      end

      S_RAMP: begin
        if (pwmbp_q) begin
          if (div_cnt_q == div_q - 8'd1) begin
            ce_out    = 1'b1;
            div_cnt_d = 8'd0;
            ce_seen_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + 8'd1;
          end
        end
        // ZERO only counts once a CE has really moved the channel, so a
        // start level of 0 still ramps. Abort takes priority over completion.
        if (bus.ABORT) begin
          state_d = S_KILL;
        end else if (bus.ZERO && ce_seen_q) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end

      S_KILL: begin
        l_out       = 1'b1;
        d_out       = 8'd0;
        aborted_out = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      pwmbp_q   <= 1'b0;
      level_q   <= 8'd0;
      div_q     <= 8'd1;
      div_cnt_q <= 8'd0;
      ce_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      pwmbp_q   <= pwmbp_d;
      level_q   <= level_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      ce_seen_q <= ce_seen_d;
    end
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.BUSY      = busy;
  assign bus.PWMBP     = pwmbp_q;
  assign bus.L         = l_out;
  assign bus.D         = d_out;
  assign bus.CE        = ce_out;
  assign bus.DONE      = done_out;
  assign bus.ABORTED   = aborted_out;

endmodule

// File: doc/trapezoid_step_sequencer.md
# trapezoid_step_sequencer

Sequences one trapezoid PWM current channel for the stepper driver. It generates the PWM base-period strobe, loads the start level, and issues ramp count-enables at a programmable PWM-period divisor. It also detects ramp completion through the channel's ZERO flag. It sits between the step-command source and the trapezoid PWM channel and drives that channel's PWMBP, D, L and CE inputs.

## Interface
- PWM_PERIOD, default 2048: clocks per PWM base period (matches 11-bit PWM counter); legal ≥ 2.
- CLK  in  1  system clock, all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  step command valid.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_LEVEL  in  8  start level, loaded to the PWM channel.
- CMD_DIV  in  8  CE divisor in PWM periods; 0 treated as 1.
- ABORT  in  1  terminate the active ramp.
- PWMBP  out  1  one-cycle PWM base-period pulse.
- D  out  8  load data to the PWM channel.
- L  out  1  one-cycle load strobe.
- CE  out  1  one-cycle ramp count enable.
- ZERO  in  1  PWM channel level == 0, combinational from the channel.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle pulse on normal ramp completion.
- ABORTED  out  1  one-cycle pulse on abort completion.

## Operation
- Period counter: free-running 0..PWM_PERIOD-1 and wraps; runs in every state. PWMBP is a registered one-cycle pulse on each wrap.
- Command handshake: a transfer occurs when CMD_VALID && CMD_READY at a rising edge. CMD_LEVEL and CMD_DIV are latched on transfer; a latched CMD_DIV of 0 is stored as 1.
- States:
  - IDLE: CMD_READY=1, BUSY=0. A transfer moves to LOAD.
  - LOAD: one cycle, L=1, D=latched level. Clears the divisor counter and the ce_seen flag, then moves to RAMP.
  - RAMP: the divisor counter increments on each PWMBP. When the PWMBP that reaches div-1 occurs, CE=1 in that same cycle, the counter clears and ce_seen is set.
    - If ZERO=1 and ce_seen=1 in a cycle, the next cycle has DONE=1 and the state returns to IDLE.
    - If ABORT=1, the state moves to KILL.
  - KILL: one cycle, L=1, D=0, ABORTED=1, then IDLE.
- ABORT rules:
  - ABORT in LOAD: the LOAD strobe still issues, then KILL.
  - ABORT in IDLE or KILL: ignored.
- Simultaneous ABORT and completing ZERO in RAMP: ABORT wins; ABORTED pulses, DONE does not.
- No CE outside RAMP. CE never coincides with L.
- ZERO is ignored until ce_seen is set, so CMD_LEVEL=0 ramps normally.
- Widths: divisor counter is 8 bits, period counter is ceil(log2(PWM_PERIOD)) bits, and no counter overflows.

## Timing
- Reset (RSTN low, asynchronous):
  - State IDLE, all counters 0.
  - PWMBP=L=CE=DONE=ABORTED=BUSY=0, D=0, CMD_READY=1.
- First PWMBP is high in the cycle after the PWM_PERIOD-th rising edge following RSTN deassertion, then every PWM_PERIOD cycles.
- Command latency: transfer at edge t gives L=1 during cycle t+1. RAMP starts at t+2.
- BUSY runs from t+1 through the DONE or ABORTED cycle inclusive.
- First CE is on the CMD_DIV-th PWMBP after RAMP entry, and every CMD_DIV PWMBPs thereafter.
- DONE is one cycle after the first qualifying ZERO sample. CMD_READY is high the cycle after DONE or ABORTED.
- ABORT sampled at edge t gives L=1 with D=0 and ABORTED=1 during cycle t+1.
- Reset mid-operation: immediate return to reset values, with no L, DONE or ABORTED issued.

## Test plan
- Reset/period, PWM_PERIOD=2048: PWMBP first high 2048 cycles after reset release, then period 2048. L/CE/DONE stay 0 and CMD_READY=1 throughout.
- Normal step, level 100, div 2: L=1 with D=100 one cycle after handshake. CE coincides with the 2nd, 4th and 6th PWMBP. The bench raises ZERO after the 3rd CE; DONE pulses one cycle later and CMD_READY returns.
- Divisor 0, level 0: CE on every PWMBP. ZERO=1 before the first CE is ignored; completion only after a CE.
- Abort mid-ramp: ABORT after the 2nd CE gives next-cycle L=1, D=0, ABORTED=1, no DONE, and no further CE.
- ABORT and qualifying ZERO in the same cycle: ABORTED only. Separately, CMD_VALID held during BUSY is not accepted until IDLE.
- RSTN pulsed low mid-RAMP: outputs immediately at reset values, and the period counter restarts so the first PWMBP lands 2048 cycles after release.
